mem_seg_reg: RTL and testbench
==============================

Name: mem_seg_reg

Overview:
EX-MEM pipeline stage. It captures the EX-stage results and control signals that the ID-EX segment register forwarded into EX, and presents them to the MEM stage. It also owns the data-memory request handshake: it byte-aligns stores, issues one request per memory instruction, and stalls the whole pipeline until the memory acknowledges the request or a timeout fires.

Parameters:
WAIT_TIMEOUT, 15, maximum number of ACCESS cycles without MemAckM before the access is aborted (legal range 1..255).

Ports:
clk  in  1  pipeline clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  stage enable from the hazard unit; 0 means hold.
clear  in  1  synchronous flush; acts only when en=1.
AluOutE  in  32  ALU result, which is the memory address for loads and stores.
StoreDataE  in  32  forwarded rs2 value.
RdE  in  5  destination register.
PCE  in  32  instruction PC.
RegWriteE  in  3  load/writeback type code; passed through unchanged.
MemToRegE  in  1  instruction is a load.
MemWriteE  in  4  byte mask for offset 0: 0001=SB, 0011=SH, 1111=SW.
LoadNpcE  in  1  writeback selects PC+4.
AluOutM  out  32  registered AluOutE.
StoreDataM  out  32  aligned store data.
RdM  out  5  registered RdE.
PCM  out  32  registered PCE.
RegWriteM  out  3  registered RegWriteE.
MemToRegM  out  1  registered MemToRegE.
MemWriteM  out  4  aligned byte mask.
LoadNpcM  out  1  registered LoadNpcE.
MemReqM  out  1  data-memory request.
MemAckM  in  1  data-memory completion, single-cycle pulse.
StallMem  out  1  freeze request for all upstream stages and this stage.
MisalignM  out  1  current store was misaligned and has been suppressed.
MemTimeout  out  1  sticky error flag.

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE.
- Capture: on a rising edge with en=1, StallMem=0 and clear=0, all E inputs are registered. Latency is 1 cycle.
- Flush: if clear=1 at that edge, every M output is zeroed instead.
- Hold: with en=0, all state holds and clear is ignored.
- Alignment: offset = AluOutE[1:0].
  - MemWriteM = MemWriteE << offset, truncated to 4 bits.
  - StoreDataM = StoreDataE << (8*offset).
  - If any mask bit would shift out past bit 3, the store is misaligned: MemWriteM=0000 and MisalignM=1 for that instruction.
- FSM states: IDLE, ACCESS.
  - IDLE to ACCESS: at a capture edge where the captured instruction is an access, meaning MemToRegE=1 or the aligned MemWrite is nonzero.
  - ACCESS: MemReqM=1 and StallMem = ~MemAckM (combinational).
  - ACCESS to IDLE: on the cycle MemAckM=1. That same edge may capture the next instruction, so there is no bubble after the ack.
  - ACCESS to IDLE on timeout: the wait counter increments each ACCESS cycle without an ack. When it reaches WAIT_TIMEOUT, the FSM goes to IDLE, MemTimeout is set (sticky until reset), and MemWriteM and MemToRegM are zeroed.
- MemAckM in IDLE is ignored.
- clear while in ACCESS is ignored, because an outstanding request is never withdrawn.
- Reset asserted mid-ACCESS drops the request immediately; MemReqM falls asynchronously.
- The wait counter clears on entry to ACCESS.

Optional Feature:
MEM_PERF_CNT_EN:
- Defined: adds two 32-bit output ports.
  - PerfAccCnt: counts IDLE-to-ACCESS transitions.
  - PerfStallCnt: counts cycles with StallMem=1.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. SW at AluOutE=0x100, StoreDataE=0xDEADBEEF, MemWriteE=1111, ack on the 3rd ACCESS cycle:
   - MemReqM high for 3 cycles, StallMem high for 2.
   - MemWriteM=1111, StoreDataM=0xDEADBEEF.
2. SB at address 0x103 with data 0x000000AB: MemWriteM=1000, StoreDataM=0xAB000000, MisalignM=0.
3. SH at address 0x103: MemWriteM=0000, MisalignM=1, no request issued, StallMem stays 0.
4. Load with no ack and WAIT_TIMEOUT=15: StallMem high for 15 cycles, then MemTimeout=1 (sticky), FSM returns to IDLE, MemToRegM=0.
5. clear=1 and en=1 in IDLE: all M outputs are 0 next cycle. clear=1 during ACCESS: the request persists until ack.
6. Assert rst_n=0 during ACCESS: MemReqM, StallMem and all outputs go to 0 without a clock edge. After release, an ALU-only instruction passes in 1 cycle with MemReqM=0.

Source files
------------

// File: rtl/mem_seg_reg_if.sv
// rtl/mem_seg_reg_if.sv - data-memory request bus between the EX-MEM stage and data memory
//
// Purpose : carries the aligned memory request from the EX-MEM segment register
//           to the data memory and the single-cycle completion pulse back.
// Signals : AluOutM    - registered ALU result / memory address
//           StoreDataM - byte-aligned store data
//           MemWriteM  - byte-aligned write mask (0000 for loads and non-memory ops)
//           MemReqM    - request, high for every ACCESS cycle
//           MemAckM    - completion pulse from memory
// Modports: master - pipeline stage side; slave - memory side.
interface mem_seg_reg_if;
  logic [31:0] AluOutM;
  logic [31:0] StoreDataM;
  logic [3:0]  MemWriteM;
  logic        MemReqM;
  logic        MemAckM;

  modport master (
    output AluOutM, StoreDataM, MemWriteM, MemReqM,
    input  MemAckM
  );

  modport slave (
    input  AluOutM, StoreDataM, MemWriteM, MemReqM,
    output MemAckM
  );
endinterface

// File: rtl/mem_seg_reg.sv
// rtl/mem_seg_reg.sv - EX-MEM segment register with data-memory request handshake
//
// Purpose : registers EX-stage results for the MEM stage, byte-aligns stores,
//           issues one memory request per load/store and stalls the pipeline
//           until the memory acknowledges or WAIT_TIMEOUT cycles elapse.
// Ports   : clk, rst_n            - clock, asynchronous active-low reset
//           i_en, i_clear         - stage enable (0 = hold), synchronous flush
//           i_*E                  - EX-stage results and control
//           io_dmem (master)      - AluOutM/StoreDataM/MemWriteM/MemReqM out, MemAckM in
//           o_*M                  - remaining registered MEM-stage values
//           o_StallMem            - freeze request for upstream stages and this one
//           o_MisalignM           - captured store crossed a word boundary and was dropped
//           o_MemTimeout          - sticky: an access was aborted after WAIT_TIMEOUT cycles
// Option  : MEM_PERF_CNT_EN adds o_PerfAccCnt (accesses started) and
//           o_PerfStallCnt (cycles with o_StallMem high), both wrapping 32-bit.
module mem_seg_reg #(
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_clear,
  input  logic [31:0]   i_AluOutE,
  input  logic [31:0]   i_StoreDataE,
  input  logic [4:0]    i_RdE,
  input  logic [31:0]   i_PCE,
  input  logic [2:0]    i_RegWriteE,
  input  logic          i_MemToRegE,
  input  logic [3:0]    i_MemWriteE,
  input  logic          i_LoadNpcE,
  mem_seg_reg_if.master io_dmem,
  output logic [4:0]    o_RdM,
  output logic [31:0]   o_PCM,
  output logic [2:0]    o_RegWriteM,
  output logic          o_MemToRegM,
  output logic          o_LoadNpcM,
  output logic          o_StallMem,
  output logic          o_MisalignM,
  output logic          o_MemTimeout
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]   o_PerfAccCnt,
  output logic [31:0]   o_PerfStallCnt
`endif
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  localparam logic [7:0] LP_WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_wait;

  logic [31:0] r_AluOutM;
  logic [31:0] r_StoreDataM;
  logic [4:0]  r_RdM;
  logic [31:0] r_PCM;
  logic [2:0]  r_RegWriteM;
  logic        r_MemToRegM;
  logic [3:0]  r_MemWriteM;
  logic        r_LoadNpcM;
  logic        r_MisalignM;
  logic        r_MemTimeout;

  logic [1:0]  w_off;
  logic [6:0]  w_mask_wide;
  logic        w_misalign;
  logic [3:0]  w_mask;
  logic [31:0] w_sdata;
  logic        w_is_acc;
  logic        w_stall;
  logic        w_capture;
  logic        w_start;
  logic        w_timeout;

  // Store alignment: widen the mask so bits pushed past lane 3 are visible
  // and mark the store misaligned instead of silently wrapping.
  assign w_off       = i_AluOutE[1:0];
  assign w_mask_wide = {3'b000, i_MemWriteE} << w_off;
  assign w_misalign  = |w_mask_wide[6:4];
  assign w_mask      = w_misalign ? 4'b0000 : w_mask_wide[3:0];
  assign w_sdata     = i_StoreDataE << {w_off, 3'b000};
  assign w_is_acc    = i_MemToRegE | (|w_mask);

  // The ack cycle itself is not a stall, so the ack edge also captures the
  // next instruction; clear during a pending access is ignored because no
  // capture happens while stalled.
  assign w_stall   = (r_state == S_ACCESS) & ~io_dmem.MemAckM;
  assign w_capture = i_en & ~w_stall;
  assign w_start   = w_capture & ~i_clear & w_is_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The handshake advances regardless of i_en so a single-cycle ack is never lost.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (io_dmem.MemAckM) begin
          w_state_nxt = w_start ? S_ACCESS : S_IDLE;
        end else if (r_wait == LP_WAIT_LAST) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= 8'd0;
    end else if (w_start) begin
      r_wait <= 8'd0;
    end else if ((r_state == S_ACCESS) && !io_dmem.MemAckM) begin
      r_wait <= r_wait + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_AluOutM    <= '0;
      r_StoreDataM <= '0;
      r_RdM        <= '0;
      r_PCM        <= '0;
      r_RegWriteM  <= '0;
      r_MemToRegM  <= 1'b0;
      r_MemWriteM  <= '0;
      r_LoadNpcM   <= 1'b0;
      r_MisalignM  <= 1'b0;
      r_MemTimeout <= 1'b0;
    end else begin
      if (w_capture) begin
        if (i_clear) begin
          r_AluOutM    <= '0;
          r_StoreDataM <= '0;
          r_RdM        <= '0;
          r_PCM        <= '0;
          r_RegWriteM  <= '0;
          r_MemToRegM  <= 1'b0;
          r_MemWriteM  <= '0;
          r_LoadNpcM   <= 1'b0;
          r_MisalignM  <= 1'b0;
        end else begin
          r_AluOutM    <= i_AluOutE;
          r_StoreDataM <= w_sdata;
          r_RdM        <= i_RdE;
          r_PCM        <= i_PCE;
          r_RegWriteM  <= i_RegWriteE;
          r_MemToRegM  <= i_MemToRegE;
          r_MemWriteM  <= w_mask;
          r_LoadNpcM   <= i_LoadNpcE;
          r_MisalignM  <= w_misalign;
        end
      end else if (w_timeout) begin
        // An aborted access must not write memory or the register file.
        r_MemWriteM <= '0;
        r_MemToRegM <= 1'b0;
      end
      if (w_timeout) r_MemTimeout <= 1'b1;
    end
  end

  assign io_dmem.AluOutM    = r_AluOutM;
  assign io_dmem.StoreDataM = r_StoreDataM;
  assign io_dmem.MemWriteM  = r_MemWriteM;
  assign io_dmem.MemReqM    = (r_state == S_ACCESS);
  assign o_RdM              = r_RdM;
  assign o_PCM              = r_PCM;
  assign o_RegWriteM        = r_RegWriteM;
  assign o_MemToRegM        = r_MemToRegM;
  assign o_LoadNpcM         = r_LoadNpcM;
  assign o_StallMem         = w_stall;
  assign o_MisalignM        = r_MisalignM;
  assign o_MemTimeout       = r_MemTimeout;

`ifdef MEM_PERF_CNT_EN
  logic [31:0] r_perf_acc;
  logic [31:0] r_perf_stall;

  // Every access start is counted, including one launched on the ack edge of
  // the previous access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_acc   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_start) r_perf_acc   <= r_perf_acc + 32'd1;
      if (w_stall) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign o_PerfAccCnt   = r_perf_acc;
  assign o_PerfStallCnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_mem_seg_reg.sv
// tb/tb_mem_seg_reg.sv - scoreboard testbench for mem_seg_reg
module tb_mem_seg_reg;
  localparam int WAIT_TIMEOUT = 15;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [2:0]  rw;
    logic        mtr;
    logic [3:0]  mw;
    logic        npc;
  } instr_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [2:0]  rw;
    logic        mtr;
    logic [3:0]  mw;
    logic        npc;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, en, clear;
  logic [31:0] AluOutE, StoreDataE, PCE;
  logic [4:0]  RdE;
  logic [2:0]  RegWriteE;
  logic        MemToRegE, LoadNpcE;
  logic [3:0]  MemWriteE;
  logic [4:0]  RdM;
  logic [31:0] PCM;
  logic [2:0]  RegWriteM;
  logic        MemToRegM, LoadNpcM, StallMem, MisalignM, MemTimeout;
`ifdef MEM_PERF_CNT_EN
  logic [31:0] PerfAccCnt, PerfStallCnt;
`endif

  mem_seg_reg_if dmem_if();

  mem_seg_reg #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (en),
    .i_clear      (clear),
    .i_AluOutE    (AluOutE),
    .i_StoreDataE (StoreDataE),
    .i_RdE        (RdE),
    .i_PCE        (PCE),
    .i_RegWriteE  (RegWriteE),
    .i_MemToRegE  (MemToRegE),
    .i_MemWriteE  (MemWriteE),
    .i_LoadNpcE   (LoadNpcE),
    .io_dmem      (dmem_if),
    .o_RdM        (RdM),
    .o_PCM        (PCM),
    .o_RegWriteM  (RegWriteM),
    .o_MemToRegM  (MemToRegM),
    .o_LoadNpcM   (LoadNpcM),
    .o_StallMem   (StallMem),
    .o_MisalignM  (MisalignM),
    .o_MemTimeout (MemTimeout)
`ifdef MEM_PERF_CNT_EN
    ,
    .o_PerfAccCnt   (PerfAccCnt),
    .o_PerfStallCnt (PerfStallCnt)
`endif
  );

  always #5 clk = ~clk;

  int     tests = 0;
  int     errors = 0;
  exp_t   exp_q[$];
  int     lat_q[$];
  exp_t   cur;
  bit     m_busy;
  int     m_wait;
  bit     m_to;
  bit     mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: shift the mask/data with plain arithmetic; a mask value above
  // 15 after scaling means a lane left the word.
  function automatic exp_t expect_of(input instr_t i, input bit clr);
    exp_t e;
    int   off;
    int   m;
    e = '0;
    if (clr) return e;
    off   = int'(i.addr % 32'd4);
    m     = int'(i.mw) * (1 << off);
    e.alu = i.addr;
    e.sd  = i.sd * (32'd1 << (8 * off));
    e.pc  = i.pc;
    e.rd  = i.rd;
    e.rw  = i.rw;
    e.mtr = i.mtr;
    e.npc = i.npc;
    e.mis = (m > 15);
    e.mw  = e.mis ? 4'd0 : 4'(m);
    return e;
  endfunction

  function automatic instr_t mk(input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] mw, input logic mtr);
    instr_t i;
    i.addr = a;
    i.sd   = d;
    i.mw   = mw;
    i.mtr  = mtr;
    i.pc   = $urandom;
    i.rd   = 5'($urandom);
    i.rw   = 3'($urandom);
    i.npc  = 1'($urandom);
    return i;
  endfunction

  task automatic drive(input instr_t i);
    AluOutE    = i.addr;
    StoreDataE = i.sd;
    RdE        = i.rd;
    PCE        = i.pc;
    RegWriteE  = i.rw;
    MemToRegE  = i.mtr;
    MemWriteE  = i.mw;
    LoadNpcE   = i.npc;
  endtask

  task automatic model_reset();
    cur    = '0;
    m_busy = 1'b0;
    m_wait = 0;
    m_to   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_AluOutM"},    dmem_if.AluOutM, 32'd0);
    check({tag, "_StoreDataM"}, dmem_if.StoreDataM, 32'd0);
    check({tag, "_MemWriteM"},  32'(dmem_if.MemWriteM), 32'd0);
    check({tag, "_MemReqM"},    32'(dmem_if.MemReqM), 32'd0);
    check({tag, "_StallMem"},   32'(StallMem), 32'd0);
    check({tag, "_RdM"},        32'(RdM), 32'd0);
    check({tag, "_PCM"},        PCM, 32'd0);
    check({tag, "_RegWriteM"},  32'(RegWriteM), 32'd0);
    check({tag, "_MemToRegM"},  32'(MemToRegM), 32'd0);
    check({tag, "_LoadNpcM"},   32'(LoadNpcM), 32'd0);
    check({tag, "_MisalignM"},  32'(MisalignM), 32'd0);
    check({tag, "_MemTimeout"}, 32'(MemTimeout), 32'd0);
  endtask

  // Present an instruction, optionally after en=0 hold cycles (with random
  // clear, which must be ignored), push its expected result, then keep it on
  // the inputs until the stage is no longer stalled.
  task automatic issue(input instr_t ins, input bit clr, input int hold);
    int n;
    for (int k = 0; k < hold; k++) begin
      drive(ins);
      en    = 1'b0;
      clear = 1'($urandom_range(0, 1));
      @(posedge clk);
      #2;
    end
    drive(ins);
    en    = 1'b1;
    clear = clr;
    exp_q.push_back(expect_of(ins, clr));
    n = 0;
    @(negedge clk);
    while (StallMem === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++;
      errors++;
      $display("FAIL accept_wait: stall held %0d cycles, required release", n);
    end
    @(posedge clk);
    #2;
  endtask

  // Memory responder: per access latency from lat_q (0 = never ack) or random;
  // occasionally pulses a stray ack while no request is pending.
  initial begin
    int cnt;
    int lat;
    bit acked;
    bit prev_req;
    cnt = 0; lat = 0; acked = 1'b0; prev_req = 1'b0;
    dmem_if.MemAckM = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (dmem_if.MemReqM === 1'b1) begin
        if (!prev_req || acked) begin
          if (lat_q.size() > 0) lat = lat_q.pop_front();
          else lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
          cnt = 1;
        end else begin
          cnt++;
        end
        acked = (lat != 0) && (cnt == lat);
        dmem_if.MemAckM = acked;
        prev_req = 1'b1;
      end else begin
        acked = 1'b0;
        dmem_if.MemAckM = ($urandom_range(0, 5) == 0);
        prev_req = 1'b0;
      end
    end
  end

  // Monitor: behavioural model of the pending access, advanced once per edge
  // from the sampled inputs; pops the scoreboard whenever the stage accepts.
  initial begin
    bit s_en;
    bit s_ack;
    bit e_stall;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        s_en    = en;
        s_ack   = dmem_if.MemAckM;
        e_stall = m_busy && !s_ack;
        check("MemReqM",  32'(dmem_if.MemReqM), 32'(m_busy));
        check("StallMem", 32'(StallMem), 32'(e_stall));
        if (m_busy) begin
          if (s_ack) begin
            m_busy = 1'b0;
          end else begin
            m_wait++;
            if (m_wait >= WAIT_TIMEOUT) begin
              m_busy  = 1'b0;
              m_to    = 1'b1;
              cur.mtr = 1'b0;
              cur.mw  = 4'd0;
            end
          end
        end
        if (s_en && !e_stall) begin
          tests++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: capture with empty queue, got 1 capture required 0 at %0t", $time);
          end else begin
            cur = exp_q.pop_front();
            if (cur.mtr || cur.mw != 4'd0) begin
              m_busy = 1'b1;
              m_wait = 0;
            end
          end
        end
        @(posedge clk);
        #1;
        if (mon_on) begin
          check("AluOutM",    dmem_if.AluOutM, cur.alu);
          check("StoreDataM", dmem_if.StoreDataM, cur.sd);
          check("MemWriteM",  32'(dmem_if.MemWriteM), 32'(cur.mw));
          check("RdM",        32'(RdM), 32'(cur.rd));
          check("PCM",        PCM, cur.pc);
          check("RegWriteM",  32'(RegWriteM), 32'(cur.rw));
          check("MemToRegM",  32'(MemToRegM), 32'(cur.mtr));
          check("LoadNpcM",   32'(LoadNpcM), 32'(cur.npc));
          check("MisalignM",  32'(MisalignM), 32'(cur.mis));
          check("MemTimeout", 32'(MemTimeout), 32'(m_to));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] masks [4];
    logic [3:0] mw;
    logic       mtr;
    instr_t     ins;
    masks = '{4'h0, 4'h1, 4'h3, 4'hF};
    rst_n = 1'b0;
    en    = 1'b0;
    clear = 1'b0;
    drive('0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_zero("reset");
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // SW, ack on third ACCESS cycle
    lat_q.push_back(3);
    issue(mk(32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 1'b0), 1'b0, 0);
    // SB to byte 3
    lat_q.push_back(2);
    issue(mk(32'h0000_0103, 32'h0000_00AB, 4'b0001, 1'b0), 1'b0, 0);
    // SH to byte 3: misaligned, no request
    issue(mk(32'h0000_0103, 32'h0000_1234, 4'b0011, 1'b0), 1'b0, 0);
    // load never acked: timeout
    lat_q.push_back(0);
    issue(mk(32'h0000_0200, 32'h0, 4'b0000, 1'b1), 1'b0, 0);
    // flush presented during the timed-out access, accepted in IDLE
    issue(mk(32'h0000_0055, 32'h1111_2222, 4'b1111, 1'b0), 1'b1, 0);
    // load with ack after 4 cycles, flush presented while it is pending
    lat_q.push_back(4);
    issue(mk(32'h0000_0404, 32'h0, 4'b0000, 1'b1), 1'b0, 0);
    issue(mk(32'h0000_0408, 32'h3333_4444, 4'b0001, 1'b0), 1'b1, 0);
    issue(mk(32'h0000_0010, 32'h5555_6666, 4'b0000, 1'b0), 1'b0, 1);

    for (int n = 0; n < 200; n++) begin
      mw  = masks[$urandom_range(0, 3)];
      mtr = (mw == 4'h0) && ($urandom_range(0, 2) == 0);
      ins = mk($urandom, $urandom, mw, mtr);
      issue(ins, ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    end

    // asynchronous reset in the middle of a never-acked store
    lat_q.delete();
    lat_q.push_back(0);
    issue(mk(32'h0000_0300, 32'hCAFE_F00D, 4'b1111, 1'b0), 1'b0, 0);
    en = 1'b0;
    @(posedge clk);
    #3;
    mon_on = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n  = 1'b1;
    mon_on = 1'b1;
    issue(mk(32'h0000_0044, 32'h7777_8888, 4'b0000, 1'b0), 1'b0, 0);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
